// File: rtl/mem_access_seq.sv
// Memory access sequencer: turns single/burst read-write requests into MARin/MDRin/read/write strobes.
// Optional completed-word counter on perf_words is compiled in with `define MEMSEQ_PERF_CNT_EN.
module mem_access_seq #(
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 1,
   parameter int LEN_W       = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
   output logic [31:0]       addr_out,
   output logic              addr_oe,
   output logic              MARin,
   output logic              MDRin,
   output logic              read,
   output logic              write,
   output logic              MDRout,
   output logic              data_req,
   output logic              word_done,
   output logic              done,
   output logic              busy,
   output logic [15:0]       perf_words
);

   typedef enum logic [3:0] {
      S_IDLE, S_LD_MAR, S_RD_WAIT, S_RD_LATCH, S_RD_OUT,
      S_WR_MDR, S_WR_STROBE, S_NEXT, S_DONE
   } state_e;

   typedef struct packed {
      logic [31:0] addr_out;
      logic        addr_oe;
      logic        MARin;
      logic        MDRin;
      logic        read;
      logic        write;
      logic        MDRout;
      logic        data_req;
      logic        word_done;
      logic        done;
      logic        busy;
   } outs_t;

   localparam logic [3:0] WAIT_LD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic [3:0] WAIT_FULL = 4'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic              op_q, op_d;
   logic [3:0]        cnt_q, cnt_d;
   outs_t             out_q, out_d;

   always_comb begin : next_state
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               cur_addr_d  = addr;
               remaining_d = len;
               op_d        = we;
               state_d     = S_LD_MAR;
            end
         end
         S_LD_MAR: begin
            if (op_q) begin
               state_d = S_WR_MDR;
            end else if (WAIT_CYCLES == 0) begin
               state_d = S_RD_LATCH;
            end else begin
               state_d = S_RD_WAIT;
               cnt_d   = WAIT_LD;
            end
         end
         S_RD_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RD_LATCH;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RD_LATCH: state_d = S_RD_OUT;
         S_RD_OUT:   state_d = S_NEXT;
         S_WR_MDR: begin
            state_d = S_WR_STROBE;
            cnt_d   = WAIT_FULL;
         end
         S_WR_STROBE: begin
            if (cnt_q == 4'd0) state_d = S_NEXT;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_NEXT: begin
            if (remaining_q == '0) begin
               state_d = S_DONE;
            end else begin
               remaining_d = remaining_q - 1'b1;
               cur_addr_d  = cur_addr_q + 1'b1;
               state_d     = S_LD_MAR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state and registered alongside it,
   // so each port is a flop output that lines up exactly with its state.
   always_comb begin : decode
      out_d = '0;
      case (state_d)
         S_LD_MAR: begin
            out_d.addr_oe  = 1'b1;
            out_d.MARin    = 1'b1;
            out_d.addr_out = 32'(cur_addr_d);
         end
         S_RD_WAIT: out_d.read = 1'b1;
         S_RD_LATCH: begin
            out_d.read  = 1'b1;
            out_d.MDRin = 1'b1;
         end
         S_RD_OUT: begin
            out_d.MDRout    = 1'b1;
            out_d.word_done = 1'b1;
         end
         S_WR_MDR: begin
            out_d.data_req = 1'b1;
            out_d.MDRin    = 1'b1;
         end
         S_WR_STROBE: begin
            out_d.write     = 1'b1;
            out_d.word_done = (cnt_d == 4'd0);
         end
         S_DONE:  out_d.done = 1'b1;
         default: out_d = '0;
      endcase
      out_d.busy = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= S_IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         op_q        <= 1'b0;
         cnt_q       <= '0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
      end
   end

   assign addr_out  = out_q.addr_out;
   assign addr_oe   = out_q.addr_oe;
   assign MARin     = out_q.MARin;
   assign MDRin     = out_q.MDRin;
   assign read      = out_q.read;
   assign write     = out_q.write;
   assign MDRout    = out_q.MDRout;
   assign data_req  = out_q.data_req;
   assign word_done = out_q.word_done;
   assign done      = out_q.done;
   assign busy      = out_q.busy;

`ifdef MEMSEQ_PERF_CNT_EN
   logic [15:0] perf_q;

   // Saturating; only reset clears it.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         perf_q <= '0;
      end else if (out_q.word_done && (perf_q != 16'hFFFF)) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign perf_words = perf_q;
`else
   assign perf_words = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: random transactions against a word-level model plus
// directed waveform, wrap, held-req and mid-burst reset cases.
module tb_mem_access_seq;
   localparam int W = 1;

`ifdef MEMSEQ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   logic        req = 1'b0, we = 1'b0;
   logic [8:0]  addr = '0;
   logic [3:0]  len = '0;
   logic [31:0] addr_out;
   logic        addr_oe, MARin, MDRin, read, write, MDRout, data_req, word_done, done, busy;
   logic [15:0] perf_words;

   logic        req0 = 1'b0, we0 = 1'b0;
   logic [8:0]  addr0 = '0;
   logic [3:0]  len0 = '0;
   logic [31:0] addr_out0;
   logic        addr_oe0, MARin0, MDRin0, read0, write0, MDRout0, data_req0, word_done0, done0, busy0;
   logic [15:0] perf_words0;

   mem_access_seq #(.ADDR_W(9), .WAIT_CYCLES(W), .LEN_W(4)) dut (
      .clk(clk), .clr(clr), .req(req), .we(we), .addr(addr), .len(len),
      .addr_out(addr_out), .addr_oe(addr_oe), .MARin(MARin), .MDRin(MDRin),
      .read(read), .write(write), .MDRout(MDRout), .data_req(data_req),
      .word_done(word_done), .done(done), .busy(busy), .perf_words(perf_words));

   mem_access_seq #(.ADDR_W(9), .WAIT_CYCLES(0), .LEN_W(4)) dut0 (
      .clk(clk), .clr(clr), .req(req0), .we(we0), .addr(addr0), .len(len0),
      .addr_out(addr_out0), .addr_oe(addr_oe0), .MARin(MARin0), .MDRin(MDRin0),
      .read(read0), .write(write0), .MDRout(MDRout0), .data_req(data_req0),
      .word_done(word_done0), .done(done0), .busy(busy0), .perf_words(perf_words0));

   logic [9:0] ov, ov0;
   assign ov  = {MARin, addr_oe, MDRin, read, write, MDRout, data_req, word_done, done, busy};
   assign ov0 = {MARin0, addr_oe0, MDRin0, read0, write0, MDRout0, data_req0, word_done0, done0, busy0};

   typedef struct {
      logic        w;
      logic [8:0]  a;
      logic [31:0] d;
   } word_t;

   word_t       expq[$];
   int          latq[$];
   logic [31:0] wdq[$];
   logic [31:0] refm [512];
   logic [31:0] mem  [512];
   logic [8:0]  mar = '0;
   logic [31:0] mdr = '0;

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Memory subsystem stand-in: write uses the old MAR/MDR, then MDR load, then MAR load.
   always @(posedge clk) begin
      if (write) mem[mar] = mdr;
      if (MDRin) begin
         if (data_req) mdr = (wdq.size() > 0) ? wdq.pop_front() : 32'hBAD0BAD0;
         else          mdr = mem[mar];
      end
      if (MARin) mar = addr_out[8:0];
   end

   int         cyc = 0, t0 = 0, words = 0, wr_cnt = 0;
   logic       busy_p = 1'b0;
   logic [8:0] cur_a = '0;
   word_t      me;

   always @(negedge clk) begin
      if (!clr) begin
         words  = 0;
         busy_p = 1'b0;
      end else begin
         cyc++;
         total++;
         if ((read && write) || (MARin && MDRin) || (addr_oe && MDRout)) begin
            bad++;
            $display("FAIL invariant: strobes %b want exclusive pairs", ov);
         end
         if (busy && !busy_p) t0 = cyc;
         busy_p = busy;
         if (MARin) begin
            cur_a  = addr_out[8:0];
            wr_cnt = 0;
            chk("addr_zero_ext", {9'd0, addr_out[31:9]}, 32'd0);
         end
         if (write) wr_cnt++;
         if (word_done) begin
            words++;
            if (expq.size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_word: addr %0h want none", cur_a);
            end else begin
               me = expq.pop_front();
               chk("word_addr", 32'(cur_a), 32'(me.a));
               chk("word_data", mdr, me.d);
               if (me.w) chk("wr_strobe_len", 32'(wr_cnt), 32'(W + 1));
               else      chk("rd_mdrout", 32'(MDRout), 32'd1);
            end
         end
         if (done) begin
            if (latq.size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_done: got done want none");
            end else begin
               chk("latency", 32'(cyc - t0), 32'(latq.pop_front()));
               chk("perf_words", 32'(perf_words), PERF ? 32'((words > 65535) ? 65535 : words) : 32'd0);
            end
         end
      end
   end

   task automatic wait_idle(input bit spur);
      int n = 0;
      @(negedge clk);
      while (busy && n < 400) begin
         if (spur && !done && $urandom_range(0, 5) == 0) begin
            req = 1'b1; we = 1'($urandom); addr = 9'($urandom); len = 4'($urandom);
            @(posedge clk); #1 req = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      if (busy) begin
         total++; bad++;
         $display("FAIL idle_timeout: busy 1 want 0");
      end
   endtask

   // Called at a negedge with the DUT idle; returns just after the accepting edge.
   task automatic issue(input bit w, input logic [8:0] a, input logic [3:0] l,
                        input bit fix, input logic [31:0] fd, input bit hold);
      req = 1'b1; we = w; addr = a; len = l;
      for (int i = 0; i <= int'(l); i++) begin
         word_t e;
         e.w = w;
         e.a = a + 9'(i);
         if (w) begin
            e.d = fix ? fd : $urandom;
            refm[e.a] = e.d;
            wdq.push_back(e.d);
         end else begin
            e.d = refm[e.a];
         end
         expq.push_back(e);
      end
      latq.push_back((int'(l) + 1) * (4 + W));
      @(posedge clk); #1;
      if (!hold) req = 1'b0;
      we = 1'($urandom); addr = 9'($urandom); len = 4'($urandom);
   endtask

   logic [9:0] wv  [1:7];
   logic [9:0] wv0 [1:5];
   int         n;

   initial begin
      wv  = '{10'b1100000001, 10'b0001000001, 10'b0011000001, 10'b0000010101,
              10'b0000000001, 10'b0000000011, 10'b0000000000};
      wv0 = '{10'b1100000001, 10'b0011000001, 10'b0000010101,
              10'b0000000001, 10'b0000000011};
      for (int i = 0; i < 512; i++) begin
         mem[i]  = $urandom;
         refm[i] = mem[i];
      end

      #3 clr = 1'b0;
      #5;
      chk("rst_outs", 32'(ov), 32'd0);
      chk("rst_addr_out", addr_out, 32'd0);
      chk("rst_perf", 32'(perf_words), 32'd0);
      @(posedge clk); #1 clr = 1'b1;

      // Single read waveform, addr 0x005
      wait_idle(0);
      issue(1'b0, 9'h005, 4'd0, 1'b0, 32'd0, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk($sformatf("rd_wave_e%0d", k), 32'(ov), 32'(wv[k]));
         if (k == 1) chk("rd_wave_addr", addr_out, 32'h5);
      end

      // Zero-wait build: RD_WAIT skipped
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 9'h003; len0 = 4'd0;
      @(posedge clk); #1 req0 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("w0_wave_e%0d", k), 32'(ov0), 32'(wv0[k]));
         if (k == 1) chk("w0_addr", addr_out0, 32'h3);
      end

      // Single write of 0xDEADBEEF to 0x010
      wait_idle(0);
      issue(1'b1, 9'h010, 4'd0, 1'b1, 32'hDEADBEEF, 1'b0);
      wait_idle(0);
      chk("ram_0x010", mem[9'h010], 32'hDEADBEEF);

      // req held through a write; inputs churn; re-accept only from IDLE
      wait_idle(0);
      issue(1'b1, 9'h0A0, 4'd0, 1'b0, 32'd0, 1'b1);
      n = 0;
      @(negedge clk);
      while (!done && n < 50) begin
         we = 1'($urandom); addr = 9'($urandom); len = 4'($urandom);
         @(negedge clk);
         n++;
      end
      chk("hold_done_seen", 32'(done), 32'd1);
      we = 1'b0; addr = 9'h0A0; len = 4'd1;
      for (int i = 0; i < 2; i++) begin
         word_t e;
         e.w = 1'b0;
         e.a = 9'h0A0 + 9'(i);
         e.d = refm[e.a];
         expq.push_back(e);
      end
      latq.push_back(2 * (4 + W));
      @(posedge clk);
      @(negedge clk);
      chk("no_accept_from_done", 32'(busy), 32'd0);
      @(posedge clk); #1 req = 1'b0;
      wait_idle(0);

      // Reset in the middle of a read burst
      issue(1'b0, 9'h100, 4'd3, 1'b0, 32'd0, 1'b0);
      n = 0;
      @(negedge clk);
      while (!(read && !MDRin) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rd_wait_reached", 32'(read && !MDRin), 32'd1);
      #2 clr = 1'b0;
      #1;
      chk("midrst_outs", 32'(ov), 32'd0);
      chk("midrst_addr_out", addr_out, 32'd0);
      expq.delete(); latq.delete(); wdq.delete();
      @(posedge clk); #1 clr = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_perf", 32'(perf_words), 32'd0);

      // Burst read wrapping 0x1FE -> 0x000
      wait_idle(0);
      issue(1'b0, 9'h1FE, 4'd2, 1'b0, 32'd0, 1'b0);
      wait_idle(0);
      chk("wrap_perf", 32'(perf_words), PERF ? 32'd3 : 32'd0);
      chk("wrap_words_consumed", 32'(expq.size()), 32'd0);

      // Random traffic with spurious req pulses while busy
      for (int t = 0; t < 40; t++) begin
         logic [3:0] l;
         l = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
         wait_idle(1);
         issue(1'($urandom), 9'($urandom), l, 1'b0, 32'd0, 1'b0);
      end
      wait_idle(1);
      @(negedge clk);
      chk("queues_drained", 32'(expq.size() + latq.size() + wdq.size()), 32'd0);
      n = 0;
      for (int i = 0; i < 512; i++) if (mem[i] !== refm[i]) n++;
      chk("mem_image", 32'(n), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1, "watchdog");
   end
endmodule
